// File: rtl/alu_issue_pkg.sv
// rtl/alu_issue_pkg.sv - opcode, ALU code and state definitions shared by the issue stage
package alu_issue_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [5:0] ADD  = 6'b000000;
  localparam logic [5:0] SUB  = 6'b001000;
  localparam logic [5:0] SLL  = 6'b000001;
  localparam logic [5:0] SLT  = 6'b000010;
  localparam logic [5:0] SLTU = 6'b000011;
  localparam logic [5:0] XOR  = 6'b000100;
  localparam logic [5:0] SRL  = 6'b000101;
  localparam logic [5:0] SRA  = 6'b001101;
  localparam logic [5:0] OR   = 6'b000110;
  localparam logic [5:0] AND  = 6'b000111;
  localparam logic [5:0] BEQ  = 6'b010000;
  localparam logic [5:0] BNE  = 6'b010001;
  localparam logic [5:0] BLT  = 6'b010100;
  localparam logic [5:0] BGE  = 6'b010101;
  localparam logic [5:0] BLTU = 6'b010110;
  localparam logic [5:0] BGEU = 6'b010111;
  localparam logic [5:0] JAL  = 6'b011111;
  localparam logic [5:0] JALR = 6'b111111;

  typedef enum logic {ST_EMPTY, ST_FULL} state_e;

  typedef enum logic [2:0] {
    SEL_RS, SEL_IMM, SEL_SHAMT, SEL_LUI, SEL_AUIPC, SEL_LINK
  } opsel_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// rtl/alu_ctrl_decode.sv - combinational RV32I decode: ALU code, immediate, operand select
module alu_ctrl_decode
  import alu_issue_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instruction_i,
  output logic [5:0]      alu_ctrl_o,
  output logic            branch_op_o,
  output logic            illegal_o,
  output logic [XLEN-1:0] imm_o,
  output opsel_e          opsel_o
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic        b30;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;

  assign opcode = instruction_i[6:0];
  assign f3     = instruction_i[14:12];
  assign b30    = instruction_i[30];

  assign imm_i = {{20{instruction_i[31]}}, instruction_i[31:20]};
  assign imm_s = {{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
  assign imm_b = {{19{instruction_i[31]}}, instruction_i[31], instruction_i[7],
                  instruction_i[30:25], instruction_i[11:8], 1'b0};
  assign imm_u = {instruction_i[31:12], 12'b0};
  assign imm_j = {{11{instruction_i[31]}}, instruction_i[31], instruction_i[19:12],
                  instruction_i[20], instruction_i[30:21], 1'b0};

  always_comb begin
    alu_ctrl_o  = ADD;
    branch_op_o = 1'b0;
    illegal_o   = 1'b0;
    imm32       = '0;
    opsel_o     = SEL_RS;
    case (opcode)
      OP_R: alu_ctrl_o = {2'b00, b30, f3};
      OP_I: begin
        imm32 = imm_i;
        // Only shifts use bit 30; elsewhere it is immediate data (ADDI must not become SUB).
        if (f3 == 3'b001 || f3 == 3'b101) begin
          alu_ctrl_o = {2'b00, b30, f3};
          opsel_o    = SEL_SHAMT;
        end else begin
          alu_ctrl_o = {3'b000, f3};
          opsel_o    = SEL_IMM;
        end
      end
      OP_LOAD: begin
        imm32   = imm_i;
        opsel_o = SEL_IMM;
      end
      OP_STORE: begin
        imm32   = imm_s;
        opsel_o = SEL_IMM;
      end
      OP_BRANCH: begin
        alu_ctrl_o  = {3'b010, f3};
        branch_op_o = 1'b1;
        illegal_o   = (f3 == 3'b010) || (f3 == 3'b011);
        imm32       = imm_b;
      end
      OP_JAL: begin
        alu_ctrl_o  = JAL;
        branch_op_o = 1'b1;
        imm32       = imm_j;
        opsel_o     = SEL_LINK;
      end
      OP_JALR: begin
        alu_ctrl_o  = JALR;
        branch_op_o = 1'b1;
        imm32       = imm_i;
        opsel_o     = SEL_LINK;
      end
      OP_LUI: begin
        imm32   = imm_u;
        opsel_o = SEL_LUI;
      end
      OP_AUIPC: begin
        imm32   = imm_u;
        opsel_o = SEL_AUIPC;
      end
      default: illegal_o = 1'b1;
    endcase
  end

  assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - decode/issue stage with a single-entry ID/EX register feeding the ALU
module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int          XLEN         = 32,
  parameter logic [31:0] RESET_PC_NOP = 32'h00000013
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5:0]      ALU_Control,
  output logic [XLEN-1:0] operand_A,
  output logic [XLEN-1:0] operand_B,
  output logic            branch_op,
  output logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  state_e          state_q, state_d;
  logic            accept;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] pc_q, rs1_q, rs2_q;
  opsel_e          opsel;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      instr_q <= RESET_PC_NOP;
      pc_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        instr_q <= instruction;
        pc_q    <= pc;
        rs1_q   <= rs1_data;
        rs2_q   <= rs2_data;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    in_ready = (state_q == ST_EMPTY) || out_ready || flush;
    accept   = in_valid && in_ready && !flush;
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (accept) begin
      state_d = ST_FULL;
    end else if (out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  assign out_valid  = (state_q == ST_FULL);
  assign store_data = rs2_q;

  // Decoding the held NOP yields the all-zero reset outputs without separate output flops.
  alu_ctrl_decode #(.XLEN(XLEN)) u_decode (
    .instruction_i (instr_q),
    .alu_ctrl_o    (ALU_Control),
    .branch_op_o   (branch_op),
    .illegal_o     (illegal),
    .imm_o         (imm),
    .opsel_o       (opsel)
  );

  always_comb begin
    operand_A = rs1_q;
    operand_B = rs2_q;
    case (opsel)
      SEL_IMM:   operand_B = imm;
      SEL_SHAMT: operand_B = XLEN'(instr_q[24:20]);
      SEL_LUI: begin
        operand_A = '0;
        operand_B = imm;
      end
      SEL_AUIPC: begin
        operand_A = pc_q;
        operand_B = imm;
      end
      SEL_LINK: begin
        operand_A = pc_q + XLEN'(4);
        operand_B = imm;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - scoreboard bench for alu_issue_stage
module tb_alu_issue_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] instruction, pc, rs1_data, rs2_data;
  logic [5:0]  ALU_Control;
  logic [31:0] operand_A, operand_B, store_data, imm;
  logic        branch_op, illegal;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] ins, pc, rs1, rs2;
    logic [5:0]  ctrl;
    logic [31:0] a, b, imm;
    logic        br, ill, dc;
  } vec_t;

  vec_t sb[$];

  alu_issue_stage dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .ALU_Control(ALU_Control), .operand_A(operand_A), .operand_B(operand_B),
    .branch_op(branch_op), .store_data(store_data), .imm(imm), .illegal(illegal)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(input logic [31:0] ins, input logic [31:0] p,
                              input logic [31:0] r1, input logic [31:0] r2,
                              input logic [5:0] ctrl, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] im,
                              input logic br, input logic ill, input logic dc);
    vec_t v;
    v.ins = ins; v.pc = p; v.rs1 = r1; v.rs2 = r2; v.ctrl = ctrl;
    v.a = a; v.b = b; v.imm = im; v.br = br; v.ill = ill; v.dc = dc;
    return v;
  endfunction

  task automatic drive(input vec_t v, input logic vin, input logic ordy, input logic fl);
    @(posedge clock); #1;
    in_valid = vin; instruction = v.ins; pc = v.pc; rs1_data = v.rs1; rs2_data = v.rs2;
    out_ready = ordy; flush = fl;
    @(negedge clock);
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    instruction = 32'h13; pc = '0; rs1_data = '0; rs2_data = '0;
    @(posedge clock); @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    checks++; if (ALU_Control !== 6'b0) begin errors++; $display("FAIL reset_ctrl got=%b want=000000", ALU_Control); end
    checks++; if ({operand_A, operand_B, store_data, imm} !== 128'h0) begin errors++;
      $display("FAIL reset_data got A=%h B=%h sd=%h imm=%h want 0", operand_A, operand_B, store_data, imm); end
    checks++; if ({branch_op, illegal} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b%b want=00", branch_op, illegal); end
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_decode;
    vec_t v[13];
    vec_t e;
    logic rdy;
    v[0]  = mk(32'h402081B3, 0, 4, 5, 6'b001000, 4, 5, 0, 0, 0, 0);
    v[1]  = mk(32'hFFF00093, 0, 0, 9, 6'b000000, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0);
    v[2]  = mk(32'h4020D093, 0, 32'h80, 0, 6'b001101, 32'h80, 2, 32'h402, 0, 0, 0);
    v[3]  = mk(32'h0020F463, 0, 5, 4, 6'b010111, 5, 4, 8, 1, 0, 0);
    v[4]  = mk(32'h010000EF, 32'h100, 0, 0, 6'b011111, 32'h104, 16, 16, 1, 0, 0);
    v[5]  = mk(32'h0000007F, 0, 3, 6, 6'b000000, 0, 0, 0, 0, 1, 1);
    v[6]  = mk(32'h123452B7, 0, 7, 0, 6'b000000, 0, 32'h12345000, 32'h12345000, 0, 0, 0);
    v[7]  = mk(32'hFFFFF297, 32'h2000, 0, 0, 6'b000000, 32'h2000, 32'hFFFFF000, 32'hFFFFF000, 0, 0, 0);
    v[8]  = mk(32'hFE20AE23, 0, 32'h1000, 32'hDEADBEEF, 6'b000000, 32'h1000, 32'hFFFFFFFC, 32'hFFFFFFFC, 0, 0, 0);
    v[9]  = mk(32'h008100E7, 32'hFFFFFFFC, 32'h40, 0, 6'b111111, 0, 8, 8, 1, 0, 0);
    v[10] = mk(32'h00002063, 0, 0, 0, 6'b010010, 0, 0, 0, 1, 1, 1);
    v[11] = mk(32'hFFF0B093, 0, 32'h10, 0, 6'b000011, 32'h10, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0);
    v[12] = mk(32'h0020C1B3, 0, 32'hF0, 32'h0F, 6'b000100, 32'hF0, 32'h0F, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      logic vin = (i < 13);
      drive(v[i < 13 ? i : 0], vin, 1'b1, 1'b0);
      checks++; if (out_valid !== (sb.size() != 0)) begin errors++; $display("FAIL dec_valid cyc=%0d got=%b want=%b", i, out_valid, sb.size() != 0); end
      if (out_valid && sb.size() != 0) begin
        e = sb[0];
        checks++;
        if (ALU_Control !== e.ctrl || branch_op !== e.br || illegal !== e.ill || store_data !== e.rs2 ||
            (!e.dc && (operand_A !== e.a || operand_B !== e.b || imm !== e.imm))) begin
          errors++;
          $display("FAIL dec_entry ins=%h got ctrl=%b A=%h B=%h imm=%h br=%b ill=%b sd=%h want ctrl=%b A=%h B=%h imm=%h br=%b ill=%b sd=%h",
                   e.ins, ALU_Control, operand_A, operand_B, imm, branch_op, illegal, store_data,
                   e.ctrl, e.a, e.b, e.imm, e.br, e.ill, e.rs2);
        end
      end
      rdy = flush || sb.size() == 0 || out_ready;
      checks++; if (in_ready !== rdy) begin errors++; $display("FAIL dec_in_ready cyc=%0d got=%b want=%b", i, in_ready, rdy); end
      if (flush) sb.delete(); else if (sb.size() != 0 && out_ready) void'(sb.pop_front());
      if (in_valid && rdy && !flush) sb.push_back(v[i < 13 ? i : 0]);
    end
  endtask

  task automatic test_back_to_back;
    vec_t v[4];
    vec_t e;
    logic rdy;
    logic vin_t[9]  = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
    logic ordy_t[9] = '{1, 0, 0, 0, 1, 1, 1, 1, 1};
    int   sel_t[9]  = '{0, 1, 1, 1, 1, 2, 3, 0, 0};
    v[0] = mk(32'h00100093, 0, 0, 0, 6'b000000, 0, 1, 1, 0, 0, 0);
    v[1] = mk(32'h402081B3, 0, 4, 5, 6'b001000, 4, 5, 0, 0, 0, 0);
    v[2] = mk(32'h0020F463, 0, 5, 4, 6'b010111, 5, 4, 8, 1, 0, 0);
    v[3] = mk(32'h010000EF, 32'h100, 0, 0, 6'b011111, 32'h104, 16, 16, 1, 0, 0);
    for (int i = 0; i < 9; i++) begin
      drive(v[sel_t[i]], vin_t[i], ordy_t[i], 1'b0);
      checks++; if (out_valid !== (sb.size() != 0)) begin errors++; $display("FAIL b2b_valid cyc=%0d got=%b want=%b", i, out_valid, sb.size() != 0); end
      if (out_valid && sb.size() != 0) begin
        e = sb[0];
        checks++;
        if (ALU_Control !== e.ctrl || operand_A !== e.a || operand_B !== e.b || imm !== e.imm ||
            branch_op !== e.br || illegal !== e.ill || store_data !== e.rs2) begin
          errors++;
          $display("FAIL b2b_entry cyc=%0d ins=%h got ctrl=%b A=%h B=%h imm=%h want ctrl=%b A=%h B=%h imm=%h",
                   i, e.ins, ALU_Control, operand_A, operand_B, imm, e.ctrl, e.a, e.b, e.imm);
        end
      end
      rdy = flush || sb.size() == 0 || out_ready;
      checks++; if (in_ready !== rdy) begin errors++; $display("FAIL b2b_in_ready cyc=%0d got=%b want=%b", i, in_ready, rdy); end
      if (sb.size() != 0 && out_ready) void'(sb.pop_front());
      if (in_valid && rdy) sb.push_back(v[sel_t[i]]);
    end
  endtask

  task automatic test_flush;
    vec_t v[4];
    vec_t e;
    logic rdy;
    logic vin_t[7]  = '{1, 1, 1, 0, 1, 0, 0};
    logic ordy_t[7] = '{0, 0, 0, 0, 1, 1, 1};
    logic fl_t[7]   = '{0, 1, 1, 0, 0, 0, 0};
    int   sel_t[7]  = '{0, 1, 2, 0, 3, 0, 0};
    v[0] = mk(32'h00100093, 0, 0, 0, 6'b000000, 0, 1, 1, 0, 0, 0);
    v[1] = mk(32'h402081B3, 0, 4, 5, 6'b001000, 4, 5, 0, 0, 0, 0);
    v[2] = mk(32'h0020F463, 0, 5, 4, 6'b010111, 5, 4, 8, 1, 0, 0);
    v[3] = mk(32'h123452B7, 0, 7, 0, 6'b000000, 0, 32'h12345000, 32'h12345000, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      drive(v[sel_t[i]], vin_t[i], ordy_t[i], fl_t[i]);
      checks++; if (out_valid !== (sb.size() != 0)) begin errors++; $display("FAIL flush_valid cyc=%0d got=%b want=%b", i, out_valid, sb.size() != 0); end
      if (out_valid && sb.size() != 0) begin
        e = sb[0];
        checks++;
        if (ALU_Control !== e.ctrl || operand_A !== e.a || operand_B !== e.b || imm !== e.imm ||
            branch_op !== e.br || illegal !== e.ill || store_data !== e.rs2) begin
          errors++;
          $display("FAIL flush_entry cyc=%0d ins=%h got ctrl=%b A=%h B=%h want ctrl=%b A=%h B=%h",
                   i, e.ins, ALU_Control, operand_A, operand_B, e.ctrl, e.a, e.b);
        end
      end
      rdy = flush || sb.size() == 0 || out_ready;
      checks++; if (in_ready !== rdy) begin errors++; $display("FAIL flush_in_ready cyc=%0d got=%b want=%b", i, in_ready, rdy); end
      if (flush) sb.delete(); else if (sb.size() != 0 && out_ready) void'(sb.pop_front());
      if (in_valid && rdy && !flush) sb.push_back(v[sel_t[i]]);
    end
  endtask

  task automatic test_reset_mid;
    vec_t v = mk(32'h402081B3, 0, 4, 5, 6'b001000, 4, 5, 0, 0, 0, 0);
    drive(v, 1'b1, 1'b0, 1'b0);
    drive(v, 1'b0, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1 || ALU_Control !== 6'b001000) begin errors++;
      $display("FAIL rmid_pre got valid=%b ctrl=%b want valid=1 ctrl=001000", out_valid, ALU_Control); end
    #2 reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%b want=0", out_valid); end
    checks++; if (ALU_Control !== 6'b000000) begin errors++; $display("FAIL rmid_ctrl got=%b want=000000", ALU_Control); end
    checks++; if (operand_A !== 32'h0 || operand_B !== 32'h0) begin errors++;
      $display("FAIL rmid_ops got A=%h B=%h want 0", operand_A, operand_B); end
    sb.delete();
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL rmid_restart got valid=%b in_ready=%b want valid=0 in_ready=1", out_valid, in_ready); end
  endtask

  initial begin
    test_reset;
    test_decode;
    test_back_to_back;
    test_flush;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/issue stage that drives the ALU's control and operand inputs. It is the producer end of the ALU interface.
- Accepts one fetched RV32I instruction plus its register-file read data per handshake.
- Decodes the 6-bit ALU control code, generates the immediate and selects operands.
- Holds the result in a single-entry ID/EX register feeding the ALU, with stall (backpressure) and flush.

Parameters:
- XLEN, 32, datapath width of PC, register data and operands.
- RESET_PC_NOP, 32'h00000013, instruction field value held while invalid (ADDI x0,x0,0).

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in_valid  in  1  instruction/operands presented.
- in_ready  out  1  stage can accept this cycle.
- instruction  in  32  RV32I instruction word.
- pc  in  XLEN  PC of instruction.
- rs1_data  in  XLEN  register file read port 1.
- rs2_data  in  XLEN  register file read port 2.
- flush  in  1  branch/jump redirect; kill held and incoming instruction.
- out_valid  out  1  ID/EX entry valid.
- out_ready  in  1  ALU/EX stage consumes entry.
- ALU_Control  out  6  ALU operation code.
- operand_A  out  XLEN  ALU operand A.
- operand_B  out  XLEN  ALU operand B.
- branch_op  out  1  1 for conditional branch, JAL, JALR.
- store_data  out  XLEN  rs2_data carried for stores.
- imm  out  XLEN  decoded immediate, carried for branch/jump target calculation.
- illegal  out  1  held instruction has an unsupported opcode.

Behaviour:
- Reset (async): out_valid=0, ALU_Control=6'b000000, operand_A/B=0, branch_op=0, store_data=0, imm=0, illegal=0; internal instruction register=RESET_PC_NOP.
- FSM states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- Handshake and latency:
  - in_ready = EMPTY || out_ready (combinational from out_ready; no skid buffer).
  - Accept when in_valid && in_ready. The decoded entry appears on the outputs the next cycle (latency 1).
- Transitions:
  - EMPTY → FULL on accept.
  - FULL → EMPTY on out_ready && !accept.
  - FULL → FULL on out_ready && accept (back-to-back, full throughput), or on !out_ready (hold all outputs stable).
- Flush has priority over everything: next state EMPTY, the incoming instruction is dropped, and in_ready is still asserted that cycle.
- Output fields are updated only on accept; they keep their last values while EMPTY. Consumers must qualify them with out_valid.
- ALU_Control encoding, with f3 = funct3 and b30 = instruction[30]:
  - R-type (0110011): {2'b00, b30, f3}.
  - I-ALU (0010011): {2'b00, b30, f3} for f3 = 001/101; otherwise {3'b000, f3}, so ADDI never decodes as SUB.
  - BRANCH (1100011): {3'b010, f3}. f3 = 010 or 011 → illegal.
  - JAL → 6'b011111. JALR → 6'b111111.
  - LOAD, STORE, LUI, AUIPC → 6'b000000 (ADD).
  - Any other opcode: illegal=1 and 6'b000000.
- Immediates (sign-extended to XLEN): I, S, B (bit0=0), U (low 12 bits zero), J (bit0=0), per the RV32I formats.
- Operand select:
  - R-type / BRANCH: A=rs1_data, B=rs2_data.
  - I-ALU / LOAD / STORE: A=rs1_data, B=imm.
  - LUI: A=0, B=imm.
  - AUIPC: A=pc, B=imm.
  - JAL / JALR: A=pc+4 (wraps mod 2^XLEN), B=imm.
  - Shift-immediates: B = {27'b0, instruction[24:20]}.
- branch_op = 1 for BRANCH, JAL and JALR; 0 otherwise.
- Reset mid-operation: the held entry is discarded and the block restarts in EMPTY.

Decomposition:
- Package alu_issue_pkg holds:
  - opcode constants: OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC;
  - the 6-bit ALU code constants: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, BEQ, BNE, BLT, BGE, BLTU, BGEU, JAL, JALR;
  - the FSM state typedef.
- One combinational sub-module, alu_ctrl_decode: instruction → ALU_Control, branch_op, illegal, imm, operand-select code.
- The top level holds the handshake FSM and the ID/EX register.

Test Plan:
- Reset: assert reset mid-FULL → out_valid=0 and ALU_Control=000000 immediately, without waiting for a clock edge.
- Decode and operands:
  - SUB x3,x1,x2 (32'h402081B3), rs1=4, rs2=5 → next cycle ALU_Control=001000, A=4, B=5, branch_op=0.
  - ADDI x1,x0,-1 (32'hFFF00093) → ALU_Control=000000 (not SUB), B=32'hFFFFFFFF.
  - SRAI x1,x1,2 (32'h4020D093) → ALU_Control=001101, B=2.
- Branch and jump:
  - BGEU (f3=111), rs1=5, rs2=4 → ALU_Control=010111, branch_op=1.
  - JAL at pc=32'h100 → ALU_Control=011111, A=32'h104.
- Stall: hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and outputs stable. Raise out_ready → back-to-back accepts, one entry per cycle.
- Flush: assert flush with FULL and in_valid=1 → next cycle out_valid=0, incoming entry not issued.
- Illegal: opcode 7'b1111111 → illegal=1, ALU_Control=000000, out_valid=1.
